vec_datapath_mc: RTL and testbench
==================================

// Module: vec_datapath_mc
// PURPOSE
//  Multi-cycle vector processor datapath; generalises the single-cycle 128-bit core to
//  parametrised lane count/width and register depth. Adds handshaked instruction and data
//  memory ports, a FETCH/DECODE/EXEC/MEM/WB state machine, branch-on-zero, HALT and
//  illegal-op detection. Top-level compute core for the image-histogram flow; memories sit outside.
// PARAMETERS
//  LANES   8   number of vector lanes
//  LANE_W  16  bits per lane; vector width VW = LANES*LANE_W (default 128)
//  NREGS   16  vector registers; register index width RI = $clog2(NREGS), ISA fixes 4 bits
//  PC_W    18  program counter width; instruction width fixed at 18
//  ADDR_W  13  data memory word address width (one word = VW bits)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  imem_req    out  1       instruction fetch request, held until imem_ack
//  imem_addr   out  PC_W    fetch address (= pc)
//  imem_ack    in   1       fetch complete; imem_data valid this cycle
//  imem_data   in   18      instruction word
//  dmem_req    out  1       data access request, held until dmem_ack
//  dmem_we     out  1       1 = store, 0 = load; stable while dmem_req
//  dmem_addr   out  ADDR_W  lane0 of rs1, low ADDR_W bits
//  dmem_wdata  out  VW      store data (rs2)
//  dmem_ack    in   1       access complete; dmem_rdata valid this cycle on load
//  dmem_rdata  in   VW      load data
//  pc          out  PC_W    current program counter
//  halted      out  1       1 after HALT retires
//  illegal_op  out  1       sticky: undefined opcode decoded
// BEHAVIOUR
//  Reset (async): pc=0, all regs=0, state=FETCH, imem_req=dmem_req=dmem_we=0, halted=0,
//   illegal_op=0, dmem_addr/wdata=0. Reset mid-access drops req combinationally; late ack ignored.
//  Fields: op=[17:12], rd=[11:8], rs1=[7:4], rs2=[3:0], off=[11:0] signed word offset.
//  Opcodes: 0 NOP, 1 VADD rd=rs1+rs2, 2 VSUB rd=rs1-rs2, 3 VINC rd=rs1+1 per lane,
//   4 VLD rd=mem[rs1.l0], 5 VST mem[rs1.l0]=rs2, 6 BEQZ (rs1==0 all lanes) pc=pc+4+(off<<2),
//   7 JMP pc=pc+4+(off<<2), 8 HALT; 9..63 illegal -> illegal_op=1, executed as NOP.
//   BEQZ/JMP compare/branch on rd field bits as part of off (rd unused).
//  States: FETCH (imem_req=1 until ack; IR<=imem_data) -> DECODE (operands registered)
//   -> EXEC (lane ALU; branch resolve; VLD/VST->MEM, HALT->HALT, others->WB)
//   -> MEM (dmem_req=1 until ack) -> WB (regfile write if ALU/VLD; pc update) -> FETCH.
//  Latency with zero-wait ack: ALU/branch/NOP 4 cycles; VLD/VST 5 cycles; +1 per wait cycle.
//  Register 0 reads all-zero; writes to r0 discarded. Regfile write only in WB.
//  pc updates once per instruction in WB: +4 sequential, target on taken branch; wraps mod 2^PC_W.
//  Arithmetic lane-independent, LANE_W bits, wrap-around (no carry between lanes).
//  HALT: halted=1, no further requests; leaves only on reset.
//  imem_ack/dmem_ack outside the matching req cycle ignored; ack in same cycle as req accepted.
// CONFIGURATION
//  SATURATE_EN defined: VADD/VINC saturate unsigned at 2^LANE_W-1, VSUB clamps at 0.
//  Not defined: all lane arithmetic wraps modulo 2^LANE_W (default).
// STRUCTURE
//  vdp_pkg: opcode enum (op_e), state enum (state_e), field-slice constants, ISA widths.
//  Sub-module vdp_lane_alu: one lane add/sub/inc (+sat), generated LANES times.
//  Regfile, FSM, pc logic and memory handshakes inline in vec_datapath_mc.
// TESTING
//  1 VINC r1,r0 then VADD r2,r1,r1 -> every lane of r2 = 2; pc=8 after 8 cycles zero-wait.
//  2 lane wrap: r1 lanes=16'hFFFF, VINC r3,r1 -> lanes 0 (SATURATE_EN: 16'hFFFF);
//    VSUB r4,r0,r1 -> lanes 1 (SATURATE_EN: 0).
//  3 VST r2 to addr 5 then VLD r6 from 5, dmem_ack delayed 3 cycles -> r6==r2, req held 4 cycles.
//  4 BEQZ r0 off=-1 at pc=12 -> pc=12 (loop); BEQZ r1 nonzero -> pc=16.
//  5 opcode 6'h3F -> illegal_op=1, pc+=4, regs unchanged; HALT -> halted=1, no further imem_req.
//  6 assert reset during MEM with dmem_req=1 -> req=0 same cycle, pc=0, regs=0, refetch from 0.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared ISA definitions for vec_datapath_mc: opcodes, FSM states, instruction field positions.
package vdp_pkg;

  localparam int unsigned INSTR_W = 18;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned OFF_W   = 12;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 6'd0,
    OP_VADD = 6'd1,
    OP_VSUB = 6'd2,
    OP_VINC = 6'd3,
    OP_VLD  = 6'd4,
    OP_VST  = 6'd5,
    OP_BEQZ = 6'd6,
    OP_JMP  = 6'd7,
    OP_HALT = 6'd8
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_INC
  } alu_e;

  // Opcodes above HALT are undefined.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_HALT;
  endfunction

endpackage

// File: rtl/vdp_lane_alu.sv
// One vector lane: add / subtract / increment, wrapping by default.
// Build option SATURATE_EN: unsigned saturation (add/inc clamp high, sub clamps at 0).
module vdp_lane_alu
  import vdp_pkg::*;
#(
  parameter int unsigned LANE_W = 16
) (
  input  alu_e              i_op,
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [LANE_W-1:0] o_y_c
);

  logic [LANE_W-1:0] w_rhs;
  logic [LANE_W:0]   w_sum;
  logic [LANE_W:0]   w_dif;

  assign w_rhs = (i_op == ALU_INC) ? LANE_W'(1) : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_rhs};
  assign w_dif = {1'b0, i_a} - {1'b0, w_rhs};

  // The extra MSB is carry-out for add and borrow for subtract.
  always_comb begin
    o_y_c = w_sum[LANE_W-1:0];
    if (i_op == ALU_SUB) begin
      o_y_c = w_dif[LANE_W-1:0];
    end
`ifdef SATURATE_EN
    if (i_op == ALU_SUB) begin
      if (w_dif[LANE_W]) begin
        o_y_c = '0;
      end
    end else if (w_sum[LANE_W]) begin
      o_y_c = '1;
    end
`else
`endif
  end

endmodule

// File: rtl/vec_datapath_mc.sv
// Multi-cycle vector datapath: FETCH/DECODE/EXEC/MEM/WB with handshaked imem/dmem ports.
// Build option SATURATE_EN selects saturating lane arithmetic (see vdp_lane_alu).
module vec_datapath_mc
  import vdp_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned PC_W   = 18,
  parameter int unsigned ADDR_W = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_W-1:0]      imem_data,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic [LANES*LANE_W-1:0] dmem_wdata,
  input  logic                    dmem_ack,
  input  logic [LANES*LANE_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]         pc,
  output logic                    halted,
  output logic                    illegal_op
);

  localparam int unsigned VW = LANES * LANE_W;
  localparam int unsigned RI = $clog2(NREGS);

  state_e             r_state;
  logic [INSTR_W-1:0] r_ir;
  logic [VW-1:0]      r_rf [NREGS];
  logic [VW-1:0]      r_a;
  logic [VW-1:0]      r_b;
  logic [VW-1:0]      r_res;
  logic               r_taken;
  logic [PC_W-1:0]    r_pc;
  logic               r_imem_req;
  logic               r_dmem_req;
  logic               r_dmem_we;
  logic [ADDR_W-1:0]  r_dmem_addr;
  logic [VW-1:0]      r_dmem_wdata;
  logic               r_halted;
  logic               r_illegal;

  logic [OP_W-1:0]    w_op;
  logic [RI-1:0]      w_rd;
  logic [RI-1:0]      w_rs1;
  logic [RI-1:0]      w_rs2;
  logic [OFF_W-1:0]   w_off;
  logic [PC_W-1:0]    w_off_ext;
  logic [PC_W-1:0]    w_seq;
  logic [PC_W-1:0]    w_tgt;
  logic [VW-1:0]      w_rs1_q;
  logic [VW-1:0]      w_rs2_q;
  logic               w_a_zero;
  logic               w_wr_en;
  alu_e               w_alu_op;
  logic [VW-1:0]      w_alu_y;

  assign w_op  = r_ir[OP_LSB +: OP_W];
  assign w_rd  = r_ir[RD_LSB +: RI];
  assign w_rs1 = r_ir[RS1_LSB +: RI];
  assign w_rs2 = r_ir[RS2_LSB +: RI];
  assign w_off = r_ir[OFF_W-1:0];

  // Word offset is sign-extended, then scaled to bytes; the sum wraps mod 2^PC_W.
  assign w_off_ext = PC_W'($signed(w_off));
  assign w_seq     = r_pc + PC_W'(4);
  assign w_tgt     = w_seq + (w_off_ext << 2);

  assign w_rs1_q  = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
  assign w_rs2_q  = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
  assign w_a_zero = (r_a == '0);

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_op)
      OP_VSUB: w_alu_op = ALU_SUB;
      OP_VINC: w_alu_op = ALU_INC;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    w_wr_en = 1'b0;
    case (w_op)
      OP_VADD, OP_VSUB, OP_VINC, OP_VLD: w_wr_en = (w_rd != '0);
      default:                           w_wr_en = 1'b0;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vdp_lane_alu #(
      .LANE_W(LANE_W)
    ) u_alu (
      .i_op (w_alu_op),
      .i_a  (r_a[g*LANE_W +: LANE_W]),
      .i_b  (r_b[g*LANE_W +: LANE_W]),
      .o_y_c(w_alu_y[g*LANE_W +: LANE_W])
    );
  end

  // Sequencer, register file, pc and both memory handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_ir         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_taken      <= 1'b0;
      r_pc         <= '0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_ir       <= imem_data;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a <= w_rs1_q;
          r_b <= w_rs2_q;
          if (!op_legal(w_op)) begin
            r_illegal <= 1'b1;
          end
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_res   <= w_alu_y;
          r_taken <= (w_op == OP_JMP) || ((w_op == OP_BEQZ) && w_a_zero);
          case (w_op)
            OP_VLD, OP_VST: begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= (w_op == OP_VST);
              r_dmem_addr  <= r_a[ADDR_W-1:0];
              r_dmem_wdata <= r_b;
              r_state      <= S_MEM;
            end
            OP_HALT: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            default: r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            if (!r_dmem_we) begin
              r_res <= dmem_rdata;
            end
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (w_wr_en) begin
            r_rf[w_rd] <= r_res;
          end
          r_pc       <= r_taken ? w_tgt : w_seq;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign pc         = r_pc;
  assign halted     = r_halted;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_vec_datapath_mc.sv
// Directed bench for vec_datapath_mc: table of lane-arithmetic vectors plus hand sequences.
module tb_vec_datapath_mc;
  import vdp_pkg::*;

  localparam int unsigned VW     = 128;
  localparam int unsigned PC_W   = 18;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned NV     = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [17:0]       imem_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [VW-1:0]     dmem_wdata;
  logic              dmem_ack;
  logic [VW-1:0]     dmem_rdata;
  logic [PC_W-1:0]   pc;
  logic              halted;
  logic              illegal_op;

  logic [17:0]   rom  [64];
  logic [VW-1:0] dmem [16];
  int dwait = 0;
  int dcnt = 0;
  int dreq_cycles = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_datapath_mc dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .pc        (pc),
    .halted    (halted),
    .illegal_op(illegal_op)
  );

  // Memory models: zero-wait instruction memory, data memory acking after dwait cycles.
  assign imem_ack   = imem_req;
  assign imem_data  = rom[imem_addr[7:2]];
  assign dmem_ack   = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr[3:0]];

  always @(posedge clk) begin
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[3:0]] <= dmem_wdata;
    if (!dmem_req || dmem_ack) dcnt <= 0;
    else dcnt <= dcnt + 1;
    if (dmem_req) dreq_cycles <= dreq_cycles + 1;
  end

  typedef struct {
    string         name;
    logic [5:0]    op;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [VW-1:0] exp;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] enc(input logic [5:0] op, input int rd, input int rs1, input int rs2);
    return {op, 4'(rd), 4'(rs1), 4'(rs2)};
  endfunction

  function automatic logic [17:0] br(input logic [5:0] op, input int off);
    return {op, 12'(off)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 18'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " halted"}, VW'(halted), VW'(1));
  endtask

  task automatic wait_imem_req(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!imem_req && n < budget);
    chk({name, " imem_req seen"}, VW'(imem_req), VW'(1));
  endtask

  initial begin
    int n;
    logic [VW-1:0] ones, twos;
    ones = {8{16'h0001}};
    twos = {8{16'h0002}};

    tbl[0] = '{"vadd_lane0_wrap", OP_VADD,
               128'h0001_0002_0003_0004_0005_0006_0007_FFFF, {8{16'h0001}},
               128'h0002_0003_0004_0005_0006_0007_0008_0000};
    tbl[1] = '{"vadd_no_lane_carry", OP_VADD,
               {4{32'h0000_FFFF}}, {4{32'h0000_0001}}, {4{32'h0000_0000}}};
    tbl[2] = '{"vsub_lane0_borrow", OP_VSUB,
               128'h0010_0020_0030_0040_0050_0060_0070_0000, {8{16'h0001}},
               128'h000F_001F_002F_003F_004F_005F_006F_FFFF};
    tbl[3] = '{"vsub_zero_minus_ffff", OP_VSUB, {8{16'h0000}}, {8{16'hFFFF}}, {8{16'h0001}}};
    tbl[4] = '{"vinc_all_ffff", OP_VINC, {8{16'hFFFF}}, {8{16'h1234}}, {8{16'h0000}}};
    tbl[5] = '{"vinc_mixed", OP_VINC,
               128'hFFFF_7FFF_0000_1234_8000_00FF_FFFE_0001, {8{16'h0000}},
               128'h0000_8000_0001_1235_8001_0100_FFFF_0002};
    tbl[6] = '{"vsub_mixed", OP_VSUB, {8{16'h1234}},
               128'h1234_0234_1233_1235_0000_FFFF_1234_0001,
               128'h0000_1000_0001_FFFF_1234_1235_0000_1233};
`ifdef SATURATE_EN
    tbl[0].exp = 128'h0002_0003_0004_0005_0006_0007_0008_FFFF;
    tbl[1].exp = {4{32'h0000_FFFF}};
    tbl[2].exp = 128'h000F_001F_002F_003F_004F_005F_006F_0000;
    tbl[3].exp = {8{16'h0000}};
    tbl[4].exp = {8{16'hFFFF}};
    tbl[5].exp = 128'hFFFF_8000_0001_1235_8001_0100_FFFF_0002;
    tbl[6].exp = 128'h0000_1000_0001_0000_1234_0000_0000_1233;
`else
`endif

    clear_rom();
    for (int i = 0; i < 16; i++) dmem[i] <= '0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst pc", VW'(pc), VW'(0));
    chk("rst imem_req", VW'(imem_req), VW'(0));
    chk("rst dmem_req", VW'(dmem_req), VW'(0));
    chk("rst dmem_we", VW'(dmem_we), VW'(0));
    chk("rst halted", VW'(halted), VW'(0));
    chk("rst illegal_op", VW'(illegal_op), VW'(0));
    chk("rst dmem_addr", VW'(dmem_addr), VW'(0));
    chk("rst dmem_wdata", dmem_wdata, '0);

    // Table: r5=1; r1=mem[0]; r2=mem[1]; r3=op(r1,r2); mem[0]=r3; HALT.
    for (int i = 0; i < NV; i++) begin
      clear_rom();
      rom[0] = enc(OP_VINC, 5, 0, 0);
      rom[1] = enc(OP_VLD, 1, 0, 0);
      rom[2] = enc(OP_VLD, 2, 5, 0);
      rom[3] = enc(tbl[i].op, 3, 1, 2);
      rom[4] = enc(OP_VST, 0, 0, 3);
      rom[5] = enc(OP_HALT, 0, 0, 0);
      dmem[0] <= tbl[i].a;
      dmem[1] <= tbl[i].b;
      dwait = 0;
      do_reset();
      wait_halt(tbl[i].name, 300);
      chk({tbl[i].name, " result"}, dmem[0], tbl[i].exp);
      chk({tbl[i].name, " pc"}, VW'(pc), VW'(20));
    end

    // VINC r1,r0 ; VADD r2,r1,r1 : 4 cycles each from first request.
    clear_rom();
    rom[0] = enc(OP_VINC, 1, 0, 0);
    rom[1] = enc(OP_VADD, 2, 1, 1);
    rom[2] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    wait_imem_req("t1", 10);
    repeat (4) @(posedge clk);
    #1;
    chk("t1 pc after 4", VW'(pc), VW'(4));
    repeat (4) @(posedge clk);
    #1;
    chk("t1 pc after 8", VW'(pc), VW'(8));
    chk("t1 r2", dut.r_rf[2], twos);
    wait_halt("t1", 50);
    chk("t1 pc at halt", VW'(pc), VW'(8));

    // Store then load through a 3-wait data memory.
    clear_rom();
    rom[0] = enc(OP_VINC, 1, 0, 0);
    rom[1] = enc(OP_VADD, 2, 1, 1);
    rom[2] = enc(OP_VINC, 7, 0, 0);
    for (int i = 3; i < 7; i++) rom[i] = enc(OP_VINC, 7, 7, 0);
    rom[7] = enc(OP_VST, 0, 7, 2);
    rom[8] = enc(OP_VLD, 6, 7, 0);
    rom[9] = enc(OP_HALT, 0, 0, 0);
    dmem[5] <= '0;
    dreq_cycles <= 0;
    dwait = 3;
    do_reset();
    wait_halt("t3", 300);
    chk("t3 mem[5]", dmem[5], twos);
    chk("t3 r6", dut.r_rf[6], twos);
    chk("t3 dmem_req cycles", VW'(dreq_cycles), VW'(8));
    chk("t3 pc", VW'(pc), VW'(36));
    dwait = 0;

    // BEQZ on zero register with offset -1 loops at pc 12.
    clear_rom();
    rom[0] = enc(OP_VINC, 1, 0, 0);
    rom[3] = br(OP_BEQZ, -1);
    do_reset();
    repeat (60) @(posedge clk);
    #1;
    chk("t4 beqz loop pc", VW'(pc), VW'(12));
    chk("t4 beqz loop not halted", VW'(halted), VW'(0));

    // BEQZ on nonzero r1 falls through to pc 16.
    rom[3] = br(OP_BEQZ, 12'h010);
    rom[4] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    wait_halt("t4 nottaken", 100);
    chk("t4 nottaken pc", VW'(pc), VW'(16));

    // JMP forward skips an illegal word.
    clear_rom();
    rom[0] = br(OP_JMP, 1);
    rom[1] = {6'h3F, 12'h000};
    rom[2] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    wait_halt("t4 jmp", 100);
    chk("t4 jmp pc", VW'(pc), VW'(8));
    chk("t4 jmp skipped illegal", VW'(illegal_op), VW'(0));

    // JMP backwards from 0 wraps pc.
    clear_rom();
    rom[0]  = br(OP_JMP, -2);
    rom[63] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    wait_halt("t4 wrap", 100);
    chk("t4 wrap pc", VW'(pc), VW'(18'h3FFFC));

    // Illegal opcode acts as NOP; HALT stops fetching.
    clear_rom();
    rom[0] = enc(OP_VINC, 1, 0, 0);
    rom[1] = {6'h3F, 4'h1, 4'h1, 4'h1};
    rom[2] = enc(OP_HALT, 0, 0, 0);
    do_reset();
    wait_halt("t5", 100);
    chk("t5 illegal_op", VW'(illegal_op), VW'(1));
    chk("t5 pc", VW'(pc), VW'(8));
    chk("t5 r1 unchanged", dut.r_rf[1], ones);
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (imem_req) n++;
    end
    chk("t5 no fetch after halt", VW'(n), VW'(0));
    chk("t5 still halted", VW'(halted), VW'(1));

    // Reset while a store waits in MEM.
    clear_rom();
    rom[0] = enc(OP_VINC, 1, 0, 0);
    rom[1] = enc(OP_VST, 0, 1, 1);
    rom[2] = enc(OP_HALT, 0, 0, 0);
    dmem[1] <= '0;
    dwait = 20;
    do_reset();
    n = 0;
    while (!dmem_req && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6 dmem_req reached", VW'(dmem_req), VW'(1));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6 dmem_req dropped", VW'(dmem_req), VW'(0));
    chk("t6 pc cleared", VW'(pc), VW'(0));
    chk("t6 r1 cleared", dut.r_rf[1], '0);
    chk("t6 mem untouched", dmem[1], '0);
    dwait = 0;
    @(negedge clk);
    reset = 1'b0;
    wait_imem_req("t6 refetch", 10);
    chk("t6 refetch addr", VW'(imem_addr), VW'(0));
    wait_halt("t6", 100);
    chk("t6 store after restart", dmem[1], ones);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
